fft_frame_loader: RTL

//  Upstream feeder for the 16-point FFT input buffer.
//  - Accepts real samples on a valid/ready stream and generates the buffer's load/addr_in/xr_in write port.
//  - Counts one N-sample frame, zero-pads a short frame, then pulses fft_start.
//  - Holds off new input until the FFT core reports fft_done, so a frame in flight is never overwritten.

---
 rtl/fft_pkg.sv | 29 ++
 rtl/fft_frame_loader.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT front end.
//  - N, WIDTH, ADDR_W : default frame length, sample width and buffer address width
//  - state_t          : frame loader FSM states
//  - bitrev()         : reverses the low 'w' bits of an index (w <= 16)
package fft_pkg;

  localparam int N      = 16;
  localparam int WIDTH  = 16;
  localparam int ADDR_W = 4;

  typedef enum logic [2:0] {
    ST_FILL  = 3'd0,
    ST_PAD   = 3'd1,
    ST_FLUSH = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4
  } state_t;

  // Bit w-1-b of the result is bit b of idx; bits at or above w are zero.
  function automatic logic [15:0] bitrev(input logic [15:0] idx, input int w);
    logic [15:0] r;
    r = '0;
    for (int b = 0; b < 16; b++) begin
      if (b < w) r[w-1-b] = idx[b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_loader.sv
// fft_frame_loader
//  Feeds one N-sample frame from a valid/ready stream into the FFT input
//  buffer write port, zero-pads a frame that ends early on s_last, pulses
//  fft_start once the frame is complete and then holds off the stream until
//  the core reports fft_done.
// Ports
//  clk        rising-edge clock
//  rst_n      asynchronous active-low reset
//  s_valid    upstream sample valid
//  s_ready    sample accepted this cycle (high only while filling)
//  s_data     signed sample
//  s_last     final sample of a frame (may arrive before sample N-1)
//  buf_load   buffer write strobe (registered)
//  buf_addr   buffer write address (registered)
//  buf_xr     buffer write data (registered)
//  fft_start  one-cycle pulse: buffer holds a complete frame
//  fft_done   one-cycle pulse from the core: frame consumed
//  busy       high in every state except FILL
//  err_short  one-cycle pulse: current frame was zero-padded
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int N      = fft_pkg::N,
  parameter int WIDTH  = fft_pkg::WIDTH,
  parameter int ADDR_W = fft_pkg::ADDR_W,  // log2(N), at most 16
  parameter int BITREV = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WIDTH-1:0]  s_data,
  input  logic              s_last,
  output logic              buf_load,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [WIDTH-1:0]  buf_xr,
  output logic              fft_start,
  input  logic              fft_done,
  output logic              busy,
  output logic              err_short
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic              ready_reg, ready_next;
  logic              busy_reg, busy_next;
  logic              load_reg, load_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [WIDTH-1:0]  xr_reg, xr_next;
  logic              start_reg, start_next;
  logic              err_reg, err_next;
  logic [ADDR_W-1:0] addr_map;

  // Buffer address for the current sample index.
  assign addr_map = (BITREV != 0) ? ADDR_W'(bitrev(16'(idx_reg), ADDR_W)) : idx_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_FILL;
      idx_reg   <= '0;
      ready_reg <= 1'b0;
      busy_reg  <= 1'b0;
      load_reg  <= 1'b0;
      addr_reg  <= '0;
      xr_reg    <= '0;
      start_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      ready_reg <= ready_next;
      busy_reg  <= busy_next;
      load_reg  <= load_next;
      addr_reg  <= addr_next;
      xr_reg    <= xr_next;
      start_reg <= start_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    load_next  = 1'b0;
    addr_next  = addr_reg;
    xr_next    = xr_reg;
    err_next   = 1'b0;

    case (state_reg)
      ST_FILL: begin
        // ready_reg rather than the state is used so that nothing is taken
        // on the first edge after reset release, matching s_ready.
        if (s_valid && ready_reg) begin
          load_next = 1'b1;
          addr_next = addr_map;
          xr_next   = s_data;
          idx_next  = idx_reg + 1'b1;  // wraps to 0 after N-1
          if (idx_reg == LAST_IDX) begin
            state_next = ST_FLUSH;     // full frame; s_last here is normal
          end else if (s_last) begin
            state_next = ST_PAD;
            err_next   = 1'b1;
          end
        end
      end
      ST_PAD: begin
        load_next = 1'b1;
        addr_next = addr_map;
        xr_next   = '0;
        idx_next  = idx_reg + 1'b1;
        if (idx_reg == LAST_IDX) state_next = ST_FLUSH;
      end
      // Lets the last registered write reach the buffer before the core reads.
      ST_FLUSH: state_next = ST_START;
      ST_START: state_next = ST_WAIT;
      ST_WAIT: begin
        if (fft_done) begin
          state_next = ST_FILL;
          idx_next   = '0;
        end
      end
      default: begin
        state_next = ST_FILL;
        idx_next   = '0;
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with
  // state_reg without combinational paths to the ports.
  assign ready_next = (state_next == ST_FILL);
  assign busy_next  = (state_next != ST_FILL);
  assign start_next = (state_next == ST_START);

  assign s_ready   = ready_reg;
  assign busy      = busy_reg;
  assign buf_load  = load_reg;
  assign buf_addr  = addr_reg;
  assign buf_xr    = xr_reg;
  assign fft_start = start_reg;
  assign err_short = err_reg;

endmodule
